freq_div_prog: RTL and testbench

Runtime-programmable integer clock divider, the parametrised successor to the fixed even-ratio divider. It divides `clk` by any ratio from 2 to 2^WIDTH−1 and accepts new ratios on the fly without runts or glitches. It optionally produces a 50 % duty cycle for odd ratios, and also emits a one-cycle period strobe for logic in the `clk` domain. It sits in the clock-generation area and feeds derived clocks and enables to downstream blocks.

---
 rtl/freq_div_prog_if.sv | 22 ++
 rtl/freq_div_prog.sv | 92 +++++++++
 tb/tb_freq_div_prog.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_div_prog_if.sv
// freq_div_prog_if: control/status bundle of the programmable divider.
// master drives en/div_val/div_load; slave (divider) drives clk_div/div_tick/div_err.
interface freq_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             clk_div;
  logic             div_tick;
  logic             div_err;

  modport master (
    output en, div_val, div_load,
    input  clk_div, div_tick, div_err
  );

  modport slave (
    input  en, div_val, div_load,
    output clk_div, div_tick, div_err
  );
endinterface

// File: rtl/freq_div_prog.sv
// freq_div_prog: runtime-programmable integer divider, N in 2..2^WIDTH-1.
// Ports: clk, rst_n (async, active low); bus.slave: en, div_val, div_load
// in; clk_div, div_tick, div_err out. Macro FREQ_DIV_ODD50_EN adds a
// falling-edge flop giving 50% duty on odd N.
module freq_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  freq_div_prog_if.slave bus
);
  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             vld_q, vld_d;
  logic             q_pos_q, q_pos_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   half_pt;
  logic             last;
  logic             load_ok;
  logic             apply;

  always_comb begin
    half_pt = ({1'b0, act_q} + (WIDTH+1)'(1)) >> 1;
    last    = (cnt_q == act_q - ONE);
    load_ok = bus.div_load && (bus.div_val >= TWO);
    err_d   = bus.div_load && (bus.div_val < TWO);
    // pending N lands only where no partial phase can result
    apply   = vld_q && (!bus.en || last);
  end

  always_comb begin
    cnt_d   = (!bus.en || last) ? '0 : cnt_q + ONE;
    act_d   = apply ? pend_q : act_q;
    pend_d  = load_ok ? bus.div_val : pend_q;
    // a load on the wrap edge re-arms for the next boundary
    vld_d   = load_ok || (vld_q && !apply);
    q_pos_d = bus.en && ({1'b0, cnt_d} >= half_pt);
    tick_d  = bus.en && (cnt_d == act_q - ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      act_q   <= DEF_DIV;
      pend_q  <= DEF_DIV;
      vld_q   <= 1'b0;
      q_pos_q <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      q_pos_q <= q_pos_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

`ifdef FREQ_DIV_ODD50_EN
  logic q_neg_q, q_neg_d;

  // gated by odd N so the half-cycle extension stays with the odd period
  // that produced it, even across a reload to an even N
  always_comb begin
    q_neg_d = bus.en && q_pos_q && act_q[0];
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
    end
  end

  assign bus.clk_div = q_pos_q | q_neg_q;
`else
  assign bus.clk_div = q_pos_q;
`endif

  assign bus.div_tick = tick_q;
  assign bus.div_err  = err_q;
endmodule

// File: tb/tb_freq_div_prog.sv
// tb_freq_div_prog: self-checking bench for freq_div_prog.
// Vector table of reloads plus hand sequences for reset, gating and boundaries.
module tb_freq_div_prog;
  logic clk = 1'b0;
  logic rst_n;

  freq_div_prog_if #(.WIDTH(8)) bus ();

  freq_div_prog #(
    .WIDTH(8),
    .DEFAULT_DIV(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    logic       err;
    int         n;
  } vec_t;

  typedef struct {
    logic clk_div;
    logic tick;
  } cyc_t;

  vec_t tbl[8];
  cyc_t cq[$];
  int   pq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  // one clk cycle; sample point sits just after the falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic half();
    @(posedge clk or negedge clk);
    #1;
  endtask

  function automatic int exp_hi(input int n);
`ifdef FREQ_DIV_ODD50_EN
    return n;
`else
    return (n % 2 == 0) ? n : n - 1;
`endif
  endfunction

  function automatic int exp_lo(input int n);
`ifdef FREQ_DIV_ODD50_EN
    return n;
`else
    return (n % 2 == 0) ? n : n + 1;
`endif
  endfunction

  task automatic push_pattern(input int n, input int k0, input int cnt);
    cyc_t e;
    for (int k = k0; k < k0 + cnt; k++) begin
      e.clk_div = ((k % n) >= (n + 1) / 2);
      e.tick    = ((k % n) == n - 1);
      cq.push_back(e);
    end
  endtask

  task automatic push_one(input logic c, input logic t);
    cyc_t e;
    e.clk_div = c;
    e.tick    = t;
    cq.push_back(e);
  endtask

  task automatic drain(input string tag);
    cyc_t e;
    while (cq.size() > 0) begin
      e = cq.pop_front();
      chk({tag, "_clk_div"}, bus.clk_div, e.clk_div);
      chk({tag, "_tick"}, bus.div_tick, e.tick);
      cyc();
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (bus.div_tick !== 1'b1 && n < 600) begin
      cyc();
      n++;
    end
    chk("wait_tick_budget", bus.div_tick, 1);
  endtask

  task automatic wait_hi();
    int n = 0;
    while (!(bus.clk_div === 1'b1 && bus.div_tick === 1'b0) && n < 100) begin
      cyc();
      n++;
    end
    chk("wait_hi_budget", bus.clk_div, 1);
  endtask

  // skip current high and low, then count one high and the next low
  task automatic measure(output int hi, output int lo);
    int n = 0;
    hi = 0;
    lo = 0;
    while (bus.clk_div === 1'b1 && n < 2000) begin half(); n++; end
    while (bus.clk_div === 1'b0 && n < 2000) begin half(); n++; end
    while (bus.clk_div === 1'b1 && n < 2000) begin hi++; half(); n++; end
    while (bus.clk_div === 1'b0 && n < 2000) begin lo++; half(); n++; end
    chk("measure_budget", 32'(n < 2000), 1);
  endtask

  task automatic check_period(input string tag);
    int hi, lo, n;
    wait_tick();
    measure(hi, lo);
    n = (pq.size() > 0) ? pq.pop_front() : 0;
    chk({tag, "_hi"}, hi, exp_hi(n));
    chk({tag, "_lo"}, lo, exp_lo(n));
  endtask

  initial begin
    tbl[0] = '{val: 8'd4,   err: 1'b0, n: 4};
    tbl[1] = '{val: 8'd1,   err: 1'b1, n: 4};
    tbl[2] = '{val: 8'd0,   err: 1'b1, n: 4};
    tbl[3] = '{val: 8'd5,   err: 1'b0, n: 5};
    tbl[4] = '{val: 8'd2,   err: 1'b0, n: 2};
    tbl[5] = '{val: 8'd10,  err: 1'b0, n: 10};
    tbl[6] = '{val: 8'd255, err: 1'b0, n: 255};
    tbl[7] = '{val: 8'd6,   err: 1'b0, n: 6};

    rst_n        = 1'b0;
    bus.en       = 1'b1;
    bus.div_val  = '0;
    bus.div_load = 1'b0;
    repeat (3) cyc();
    chk("rst_clk_div", bus.clk_div, 0);
    chk("rst_tick", bus.div_tick, 0);
    chk("rst_err", bus.div_err, 0);

    // default N=6 from reset: 3 low, 3 high, tick on the 6th cycle
    rst_n = 1'b1;
    push_pattern(6, 0, 12);
    drain("dflt");

    foreach (tbl[i]) begin
      if (bus.div_tick === 1'b1) cyc();
      bus.div_val  = tbl[i].val;
      bus.div_load = 1'b1;
      pq.push_back(tbl[i].n);
      cyc();
      bus.div_load = 1'b0;
      chk("tbl_err", bus.div_err, tbl[i].err);
      if (tbl[i].err) begin
        cyc();
        chk("tbl_err_clr", bus.div_err, 0);
      end
      check_period("tbl");
    end

    // drop en while high; restart gives a full low phase
    wait_hi();
    bus.en = 1'b0;
    cyc();
    chk("gate_clk_div", bus.clk_div, 0);
    chk("gate_tick", bus.div_tick, 0);
    cyc();
    chk("gate_hold", bus.clk_div, 0);
    bus.en = 1'b1;
    push_pattern(6, 0, 7);
    drain("reen");

    // pending value taken on the en-low edge
    bus.div_val  = 8'd4;
    bus.div_load = 1'b1;
    cyc();
    bus.div_load = 1'b0;
    bus.en       = 1'b0;
    cyc();
    bus.en = 1'b1;
    push_pattern(4, 0, 8);
    drain("enapply");

    // glitch-free reload: N=4, load 10 while cnt=1
    cyc();
    bus.div_val  = 8'd10;
    bus.div_load = 1'b1;
    cyc();
    bus.div_load = 1'b0;
    push_one(1'b1, 1'b0);
    push_one(1'b1, 1'b1);
    push_pattern(10, 0, 10);
    drain("reload");

    // last request before the boundary wins
    bus.div_val  = 8'd8;
    bus.div_load = 1'b1;
    cyc();
    bus.div_val = 8'd3;
    cyc();
    bus.div_load = 1'b0;
    pq.push_back(3);
    check_period("lastwin");

    // load on the wrap edge waits one more period
    wait_tick();
    bus.div_val  = 8'd6;
    bus.div_load = 1'b1;
    cyc();
    bus.div_load = 1'b0;
    push_pattern(3, 0, 3);
    push_pattern(6, 0, 6);
    drain("wrapload");

    // async reset mid-period with a pending load
    wait_hi();
    bus.div_val  = 8'd10;
    bus.div_load = 1'b1;
    cyc();
    bus.div_load = 1'b0;
    chk("pre_rst_hi", bus.clk_div, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clk_div", bus.clk_div, 0);
    chk("arst_tick", bus.div_tick, 0);
    chk("arst_err", bus.div_err, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    push_pattern(6, 0, 14);
    drain("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
